// File: rtl/find_row_alloc_pkg.sv
// rtl/find_row_alloc_pkg.sv - shared placement types for the strip allocator
package find_row_alloc_pkg;

  // Strip record field width; keep equal to the allocator DIM_W parameter.
  localparam int STRIP_DIM_W = 5;
  localparam int NONE_ID     = 0;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_t;

  typedef struct packed {
    logic [STRIP_DIM_W-1:0] height;
    logic [STRIP_DIM_W-1:0] cap;
    logic [STRIP_DIM_W-1:0] free;
  } strip_t;

endpackage

// File: rtl/find_row_alloc_if.sv
// rtl/find_row_alloc_if.sv - config, request and response bundle of the strip allocator
interface find_row_alloc_if #(
  parameter int ID_W  = 4,
  parameter int DIM_W = 5
);

  logic             cfg_we;
  logic [ID_W-1:0]  cfg_id;
  logic [DIM_W-1:0] cfg_height;
  logic [DIM_W-1:0] cfg_cap;

  logic             req_valid;
  logic             req_ready;
  logic [DIM_W-1:0] req_height;
  logic [DIM_W-1:0] req_width;
  logic             req_commit;

  logic             rsp_valid;
  logic             rsp_found;
  logic [ID_W-1:0]  rsp_id;
  logic [DIM_W-1:0] rsp_x;

  modport master (
    output cfg_we, cfg_id, cfg_height, cfg_cap,
    output req_valid, req_height, req_width, req_commit,
    input  req_ready,
    input  rsp_valid, rsp_found, rsp_id, rsp_x
  );

  modport slave (
    input  cfg_we, cfg_id, cfg_height, cfg_cap,
    input  req_valid, req_height, req_width, req_commit,
    output req_ready,
    output rsp_valid, rsp_found, rsp_id, rsp_x
  );

endinterface

// File: rtl/find_row_alloc_strip_fit_cmp.sv
// rtl/find_row_alloc_strip_fit_cmp.sv - decides whether a scanned strip beats the current best fit
module strip_fit_cmp
  import find_row_alloc_pkg::*;
#(
  parameter int DIM_W     = 5,
  parameter int MAX_SLACK = 4
) (
  input  strip_t           cand,
  input  logic [DIM_W-1:0] req_height,
  input  logic [DIM_W-1:0] req_width,
  input  logic             best_valid,
  input  logic [DIM_W-1:0] best_slack,
  input  logic [DIM_W-1:0] best_free,
  output logic [DIM_W-1:0] slack,
  output logic             better
);

  logic fits_h;
  logic candidate;

  always_comb begin
    fits_h    = (cand.height != '0) && (cand.height >= req_height);
    // Difference only taken when it cannot wrap.
    slack     = fits_h ? (cand.height - req_height) : '0;
    candidate = fits_h && (req_height != '0) && (req_width != '0) &&
                (slack <= DIM_W'(MAX_SLACK)) && (cand.free >= req_width);
    better    = candidate &&
                (!best_valid || (slack < best_slack) ||
                 ((slack == best_slack) && (cand.free < best_free)));
  end

endmodule

// File: rtl/find_row_alloc.sv
// rtl/find_row_alloc.sv - sequential best-fit strip allocator, one strip visited per cycle
module find_row_alloc
  import find_row_alloc_pkg::*;
#(
  parameter int NUM_STRIPS = 13,
  parameter int DIM_W      = 5,
  parameter int MAX_SLACK  = 4,
  parameter int ID_W       = $clog2(NUM_STRIPS + 1)
) (
  input logic             clk,
  input logic             rst,
  find_row_alloc_if.slave bus
);

  state_t           state_q, state_d;
  strip_t           strips_q [1:NUM_STRIPS];
  logic [ID_W-1:0]  scan_idx_q, best_id_q;
  logic [DIM_W-1:0] req_h_q, req_w_q, best_slack_q, best_free_q, cand_slack;
  logic             req_c_q, best_found_q;
  logic             accept, scan_en, resp_en, cfg_ok, last_strip, better;
  strip_t           cand, best;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = SCAN;
      SCAN:    if (last_strip)    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    accept        = (state_q == IDLE) && bus.req_valid;
    scan_en       = (state_q == SCAN);
    resp_en       = (state_q == RESP);
    cfg_ok        = (state_q == IDLE) && bus.cfg_we && (bus.cfg_id != '0) &&
                    (bus.cfg_id <= ID_W'(NUM_STRIPS));
  end

  // Indices stay within 1..NUM_STRIPS, so both table reads are always in range.
  assign last_strip = (scan_idx_q == ID_W'(NUM_STRIPS));
  assign cand       = strips_q[scan_idx_q];
  assign best       = strips_q[best_id_q];

  strip_fit_cmp #(.DIM_W(DIM_W), .MAX_SLACK(MAX_SLACK)) u_cmp (
    .cand       (cand),
    .req_height (req_h_q),
    .req_width  (req_w_q),
    .best_valid (best_found_q),
    .best_slack (best_slack_q),
    .best_free  (best_free_q),
    .slack      (cand_slack),
    .better     (better)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= NUM_STRIPS; i++) strips_q[i] <= '0;
    end else begin
      if (cfg_ok)
        strips_q[bus.cfg_id] <= '{height: bus.cfg_height, cap: bus.cfg_cap, free: bus.cfg_cap};
      if (resp_en && best_found_q && req_c_q)
        strips_q[best_id_q].free <= best.free - req_w_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_h_q      <= '0;
      req_w_q      <= '0;
      req_c_q      <= 1'b0;
      scan_idx_q   <= ID_W'(1);
      best_found_q <= 1'b0;
      best_id_q    <= ID_W'(1);
      best_slack_q <= '0;
      best_free_q  <= '0;
    end else if (accept) begin
      req_h_q      <= bus.req_height;
      req_w_q      <= bus.req_width;
      req_c_q      <= bus.req_commit;
      scan_idx_q   <= ID_W'(1);
      best_found_q <= 1'b0;
      best_id_q    <= ID_W'(1);
      best_slack_q <= '0;
      best_free_q  <= '0;
    end else if (scan_en) begin
      if (!last_strip) scan_idx_q <= scan_idx_q + ID_W'(1);
      if (better) begin
        best_found_q <= 1'b1;
        best_id_q    <= scan_idx_q;
        best_slack_q <= cand_slack;
        best_free_q  <= cand.free;
      end
    end
  end

  // Result registers load on the RESP edge and hold until the next request completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_found <= 1'b0;
      bus.rsp_id    <= ID_W'(NONE_ID);
      bus.rsp_x     <= '0;
    end else begin
      bus.rsp_valid <= resp_en;
      if (resp_en) begin
        bus.rsp_found <= best_found_q;
        bus.rsp_id    <= best_found_q ? best_id_q : ID_W'(NONE_ID);
        bus.rsp_x     <= best_found_q ? (best.cap - best.free) : '0;
      end
    end
  end

endmodule

// File: tb/tb_find_row_alloc.sv
// tb/tb_find_row_alloc.sv - scoreboard bench for the strip allocator
module tb_find_row_alloc;

  localparam int NUM_STRIPS = 13;
  localparam int DIM_W      = 5;
  localparam int ID_W       = 4;
  localparam int LATENCY    = NUM_STRIPS + 1;

  typedef struct packed {
    logic             found;
    logic [ID_W-1:0]  id;
    logic [DIM_W-1:0] x;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  find_row_alloc_if #(.ID_W(ID_W), .DIM_W(DIM_W)) bus ();

  find_row_alloc #(.NUM_STRIPS(NUM_STRIPS), .DIM_W(DIM_W), .MAX_SLACK(4), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 required no response");
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_found", int'(bus.rsp_found), int'(mon_e.found));
        chk("rsp_id",    int'(bus.rsp_id),    int'(mon_e.id));
        chk("rsp_x",     int'(bus.rsp_x),     int'(mon_e.x));
      end
    end
  end

  task automatic pulse_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cfg_write(input int id, input int h, input int cap);
    bus.cfg_we     = 1'b1;
    bus.cfg_id     = ID_W'(id);
    bus.cfg_height = DIM_W'(h);
    bus.cfg_cap    = DIM_W'(cap);
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    if (!bus.req_ready) chk("ready_timeout", 0, 1);
  endtask

  // mode 0: plain request, 1: config write in the acceptance cycle, 2: config write mid-scan
  task automatic issue(input int h, input int w, input int c,
                       input int ef, input int eid, input int ex,
                       input int mode, input int cid, input int ch, input int ccap);
    int   lat = 0;
    logic got = 1'b0;
    wait_ready();
    exp_q.push_back('{found: ef[0], id: ID_W'(eid), x: DIM_W'(ex)});
    bus.req_valid  = 1'b1;
    bus.req_height = DIM_W'(h);
    bus.req_width  = DIM_W'(w);
    bus.req_commit = c[0];
    if (mode == 1) begin
      bus.cfg_we     = 1'b1;
      bus.cfg_id     = ID_W'(cid);
      bus.cfg_height = DIM_W'(ch);
      bus.cfg_cap    = DIM_W'(ccap);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.cfg_we    = 1'b0;
    while (lat < 30 && !got) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
      else begin
        lat++;
        if (mode == 2 && lat == 2) begin
          bus.cfg_we     = 1'b1;
          bus.cfg_id     = ID_W'(cid);
          bus.cfg_height = DIM_W'(ch);
          bus.cfg_cap    = DIM_W'(ccap);
        end
        if (mode == 2 && lat == 4) bus.cfg_we = 1'b0;
      end
    end
    chk("latency", lat, LATENCY);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.cfg_we = 1'b0;     bus.cfg_id = '0;    bus.cfg_height = '0; bus.cfg_cap = '0;
    bus.req_valid = 1'b0;  bus.req_height = '0; bus.req_width = '0; bus.req_commit = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_req_ready", int'(bus.req_ready), 1);
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_rsp_found", int'(bus.rsp_found), 0);
    chk("reset_rsp_id",    int'(bus.rsp_id),    0);
    chk("reset_rsp_x",     int'(bus.rsp_x),     0);

    // Smallest slack: strip 2 (h=7) for a height-7 program.
    cfg_write(1, 8, 16);
    cfg_write(2, 7, 16);
    cfg_write(3, 10, 16);
    issue(7, 4, 0, 1, 2, 0, 0, 0, 0, 0);
    issue(7, 4, 1, 1, 2, 0, 0, 0, 0, 0);
    issue(7, 4, 0, 1, 2, 4, 0, 0, 0, 0);

    // Repeated commits fill strip 1 until it no longer fits.
    pulse_reset();
    cfg_write(1, 8, 16);
    issue(8, 6, 1, 1, 1, 0, 0, 0, 0, 0);
    issue(8, 6, 1, 1, 1, 6, 0, 0, 0, 0);
    issue(8, 6, 1, 0, 0, 0, 0, 0, 0, 0);

    // Free-width tie break, then id tie break, then rejection cases.
    pulse_reset();
    cfg_write(1, 8, 10);
    cfg_write(2, 8, 6);
    issue(8, 5, 0, 1, 2, 0, 0, 0, 0, 0);
    cfg_write(2, 8, 10);
    issue(8, 5, 0, 1, 1, 0, 0, 0, 0, 0);
    issue(3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Config write during SCAN is dropped: strip 1 stays enabled.
    issue(8, 5, 0, 1, 1, 0, 2, 1, 0, 0);
    issue(8, 5, 0, 1, 1, 0, 0, 0, 0, 0);

    // Config write in the acceptance cycle is seen by that scan.
    issue(8, 5, 1, 1, 3, 0, 1, 3, 8, 5);
    issue(8, 5, 0, 1, 1, 0, 0, 0, 0, 0);

    // Reset in the 5th SCAN cycle abandons the request and clears the table.
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_height = DIM_W'(8);
    bus.req_width  = DIM_W'(1);
    bus.req_commit = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    pulse_reset();
    chk("ready_after_rst", int'(bus.req_ready), 1);
    chk("valid_after_rst", int'(bus.rsp_valid), 0);
    repeat (20) @(posedge clk);
    #1;
    issue(8, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/find_row_alloc.md
# find_row_alloc

Sequential, parametrised strip allocator for multi-program placement. It holds a configurable table of horizontal strips, each with a row height, a capacity and a remaining free width. Per request it scans the table one strip per cycle and selects the best-fit strip for a program of given height and width. Optionally it commits the allocation by consuming width from that strip. It sits between the program-request front end and the placement writer, and replaces the fixed height-to-strip lookup.

## Interface
Parameters:
- NUM_STRIPS, 13, number of strips; strip ids are 1..NUM_STRIPS, id 0 means "none"
- DIM_W, 5, width of all height/width/offset fields
- MAX_SLACK, 4, largest allowed (strip height − program height)
- ID_W, $clog2(NUM_STRIPS+1), strip id width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  strip config write; honoured only in IDLE
- cfg_id  in  ID_W  strip to write; 0 or >NUM_STRIPS ignored
- cfg_height  in  DIM_W  strip row height; 0 = strip disabled
- cfg_cap  in  DIM_W  strip capacity; free width reloads to this value
- req_valid  in  1  request present
- req_ready  out  1  high in IDLE only
- req_height  in  DIM_W  program height
- req_width  in  DIM_W  program width
- req_commit  in  1  1 = deduct width on success, 0 = query only
- rsp_valid  out  1  one-cycle result pulse
- rsp_found  out  1  a fitting strip exists
- rsp_id  out  ID_W  chosen strip, 0 if not found
- rsp_x  out  DIM_W  column offset in strip (cap − free before deduction), 0 if not found

## Operation
- FSM states: IDLE, SCAN, RESP.
  - IDLE → SCAN on req_valid && req_ready; request fields are latched.
  - SCAN visits strips 1..NUM_STRIPS in order, one strip per cycle, then moves to RESP.
  - RESP lasts one cycle, then returns to IDLE.
- A strip is a candidate when all of the following hold:
  - height ≠ 0
  - height ≥ req_height
  - height − req_height ≤ MAX_SLACK
  - free ≥ req_width
- Best fit:
  - smallest (height − req_height) wins
  - on a tie, the smaller remaining free width wins
  - on a further tie, the lowest id wins (strict-less comparison while scanning upward)
- A latched req_height or req_width of 0 gives rsp_found=0. The scan still runs to keep latency fixed.
- Commit: in RESP with rsp_found && latched commit, the chosen strip's free width becomes free − req_width. Underflow is impossible by construction.
- Config write in IDLE:
  - height ← cfg_height, cap ← cfg_cap, free ← cfg_cap
- cfg_we while in SCAN or RESP is dropped silently.
- Config write and request acceptance in the same IDLE cycle: both take effect, and the scan sees the new config.
- All arithmetic is unsigned DIM_W. Height difference is computed only when height ≥ req_height, so there is no wrap.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_found=0, rsp_id=0, rsp_x=0
  - every strip height=0, cap=0, free=0
- Latency: acceptance edge to rsp_valid high is exactly NUM_STRIPS+1 cycles. The throughput is one request per NUM_STRIPS+2 cycles.
- rsp_found/rsp_id/rsp_x are registered, valid while rsp_valid=1, and hold their values until the next RESP.
- req_ready is low from the acceptance edge until the cycle after RESP.
- There is no response backpressure; the consumer must take the pulse.
- Reset asserted mid-SCAN or mid-RESP: the request is abandoned with no rsp_valid and no commit, and the table is cleared.

## Structure
- Shared placement package holds:
  - the state enum (IDLE/SCAN/RESP)
  - the strip record typedef {height, cap, free}
  - the NONE_ID=0 constant
- One sub-module, strip_fit_cmp: combinational compare of candidate vs current best, returning "better" using the fit criteria above. The top instantiates it once inside the scan loop.

## Test plan
- Reset, config strips 1..3 as (h=8,cap=16), (h=7,cap=16), (h=10,cap=16); query h=7,w=4 → after 14 cycles rsp_found=1, rsp_id=2, rsp_x=0, free unchanged.
- Repeated commit requests h=8,w=6 against strip 1 (h=8,cap=16) only → ids 1,1 with rsp_x 0,6; third request → rsp_found=0, rsp_id=0.
- Strips 1 and 2 both h=8 with free 10 and 6, request h=8,w=5 → rsp_id=2 (tighter free). With equal free → rsp_id=1.
- Request h=3 with only h=8 strips (slack 5 > 4) → rsp_found=0. Request w=0 → rsp_found=0.
- cfg_we during SCAN → table unchanged. cfg_we and req in the same IDLE cycle → result reflects the new strip.
- Assert rst in the 5th SCAN cycle → no rsp_valid, req_ready=1 after release, all strips disabled.
